// File: rtl/adc_spi_pkg.sv
// Shared constants and state type for the ADC serial responder.
package adc_spi_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int LEAD_ZEROS   = 4;
    localparam int ADDR_MSB_BIT = 2;
    localparam int ADDR_W       = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/adc_spi_responder_sig_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with edge pulses
// derived from the synchronized level.
module sig_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Shift the pin through the synchronizer chain and remember the last level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {STAGES{RESET_VAL}};
            prev_r  <= RESET_VAL;
        end else begin
            chain_r[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
            prev_r <= chain_r[STAGES-1];
        end
    end

    assign level = chain_r[STAGES-1];
    assign rise  = chain_r[STAGES-1] & ~prev_r;
    assign fall  = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulates an 8-channel 12-bit serial ADC: CS_N/SCK/DIN are oversampled
// in the system clock domain, the channel addressed in one frame is
// returned MSB first in the next.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_50,
    input  logic                  rst_n,
    input  logic                  adc_cs_n,
    input  logic                  adc_sck,
    input  logic                  din,
    input  logic [NCH*DATA_W-1:0] ch_data,
    output logic                  dout,
    output logic                  dout_oe,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [ADDR_W-1:0]     last_addr
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    // Zero-extended sample of the selected channel, forming one frame word.
    function automatic logic [FRAME_BITS-1:0] pick_word(
        input logic [NCH*DATA_W-1:0] data,
        input logic [ADDR_W-1:0]     addr
    );
        logic [DATA_W-1:0] sample;
        sample = data[int'(addr)*DATA_W +: DATA_W];
        return FRAME_BITS'(sample);
    endfunction

    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic sck_level_s, sck_rise_s, sck_fall_s;
    logic din_level_s, din_rise_s, din_fall_s;
    logic unused_sync_s;

    sig_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk_50), .rst_n(rst_n), .async_in(adc_cs_n),
        .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    sig_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
        .clk(clk_50), .rst_n(rst_n), .async_in(adc_sck),
        .level(sck_level_s), .rise(sck_rise_s), .fall(sck_fall_s)
    );

    sig_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk(clk_50), .rst_n(rst_n), .async_in(din),
        .level(din_level_s), .rise(din_rise_s), .fall(din_fall_s)
    );

    assign unused_sync_s = &{1'b0, cs_level_s, sck_level_s, din_rise_s, din_fall_s};

    state_t                 state_r, state_s;
    logic [3:0]             bit_idx_r, bit_idx_s;
    logic                   rise_seen_r, rise_seen_s;
    logic [FRAME_BITS-1:0]  shift_r, shift_s;
    logic [ADDR_W-1:0]      addr_cur_r, addr_cur_s;
    logic [ADDR_W-1:0]      addr_nxt_r, addr_nxt_s;
    logic [ADDR_W-1:0]      last_addr_r, last_addr_s;
    logic                   dout_r, dout_s;
    logic                   dout_oe_r, dout_oe_s;
    logic                   done_r, done_s;
    logic                   abort_r, abort_s;
    logic [FRAME_BITS-1:0]  snap_s;

    assign snap_s = pick_word(ch_data, addr_cur_r);

    // State and datapath registers.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_idx_r   <= 4'd0;
            rise_seen_r <= 1'b0;
            shift_r     <= {FRAME_BITS{1'b0}};
            addr_cur_r  <= {ADDR_W{1'b0}};
            addr_nxt_r  <= {ADDR_W{1'b0}};
            last_addr_r <= {ADDR_W{1'b0}};
            dout_r      <= 1'b0;
            dout_oe_r   <= 1'b0;
            done_r      <= 1'b0;
            abort_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_idx_r   <= bit_idx_s;
            rise_seen_r <= rise_seen_s;
            shift_r     <= shift_s;
            addr_cur_r  <= addr_cur_s;
            addr_nxt_r  <= addr_nxt_s;
            last_addr_r <= last_addr_s;
            dout_r      <= dout_s;
            dout_oe_r   <= dout_oe_s;
            done_r      <= done_s;
            abort_r     <= abort_s;
        end
    end

    // Frame FSM: CS edges open/close frames, SCK rise samples DIN and ends
    // the frame at the last bit, SCK fall shifts out the next bit or wraps.
    // A fall with no preceding rise in the frame (the lead-in fall) is ignored.
    always_comb begin
        state_s     = state_r;
        bit_idx_s   = bit_idx_r;
        rise_seen_s = rise_seen_r;
        shift_s     = shift_r;
        addr_cur_s  = addr_cur_r;
        addr_nxt_s  = addr_nxt_r;
        last_addr_s = last_addr_r;
        dout_s      = dout_r;
        dout_oe_s   = dout_oe_r;
        done_s      = 1'b0;
        abort_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    state_s     = ACTIVE;
                    bit_idx_s   = 4'd0;
                    rise_seen_s = 1'b0;
                    shift_s     = snap_s;
                    dout_s      = snap_s[FRAME_BITS-1];
                    dout_oe_s   = 1'b1;
                end else begin
                    dout_s    = 1'b0;
                    dout_oe_s = 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    // CS rise takes priority over any SCK edge in the same cycle.
                    state_s     = IDLE;
                    bit_idx_s   = 4'd0;
                    rise_seen_s = 1'b0;
                    dout_s      = 1'b0;
                    dout_oe_s   = 1'b0;
                    if (rise_seen_r && (bit_idx_r == LAST_BIT)) begin
                        abort_s = 1'b0;
                    end else begin
                        abort_s = 1'b1;
                    end
                end else if (sck_rise_s) begin
                    rise_seen_s = 1'b1;
                    case (bit_idx_r)
                        4'd2:    addr_nxt_s[ADDR_MSB_BIT]   = din_level_s;
                        4'd3:    addr_nxt_s[ADDR_MSB_BIT-1] = din_level_s;
                        4'd4:    addr_nxt_s[ADDR_MSB_BIT-2] = din_level_s;
                        default: addr_nxt_s = addr_nxt_r;
                    endcase
                    if (bit_idx_r == LAST_BIT) begin
                        done_s      = 1'b1;
                        addr_cur_s  = addr_nxt_r;
                        last_addr_s = addr_nxt_r;
                    end else begin
                        done_s = 1'b0;
                    end
                end else if (sck_fall_s) begin
                    if (rise_seen_r) begin
                        rise_seen_s = 1'b0;
                        if (bit_idx_r == LAST_BIT) begin
                            // Continuous mode: start the next frame without CS.
                            bit_idx_s = 4'd0;
                            shift_s   = snap_s;
                            dout_s    = snap_s[FRAME_BITS-1];
                        end else begin
                            bit_idx_s = bit_idx_r + 4'd1;
                            shift_s   = {shift_r[FRAME_BITS-2:0], 1'b0};
                            dout_s    = shift_r[FRAME_BITS-2];
                        end
                    end else begin
                        rise_seen_s = 1'b0;
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end
            default: begin
                state_s   = IDLE;
                dout_s    = 1'b0;
                dout_oe_s = 1'b0;
            end
        endcase
    end

    assign dout        = dout_r;
    assign dout_oe     = dout_oe_r;
    assign frame_done  = done_r;
    assign frame_abort = abort_r;
    assign last_addr   = last_addr_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: acts as the ADC master, driving
// CS_N/SCK/DIN and capturing DOUT on each SCK rise.
module tb_adc_spi_responder;

    localparam int DATA_W = 12;
    localparam int NCH    = 8;
    localparam int HALF   = 8;

    logic                  clk_50 = 1'b0;
    logic                  rst_n;
    logic                  adc_cs_n;
    logic                  adc_sck;
    logic                  din;
    logic [NCH*DATA_W-1:0] ch_data;
    logic                  dout;
    logic                  dout_oe;
    logic                  frame_done;
    logic                  frame_abort;
    logic [2:0]            last_addr;

    adc_spi_responder #(.DATA_W(DATA_W), .NCH(NCH), .SYNC_STAGES(2)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck),
        .din(din), .ch_data(ch_data), .dout(dout), .dout_oe(dout_oe),
        .frame_done(frame_done), .frame_abort(frame_abort), .last_addr(last_addr)
    );

    always #10 clk_50 = ~clk_50;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   abort_cnt = 0;
    logic gap_en = 1'b0;
    logic gap_seen = 1'b0;

    // Count output pulses and watch for dout_oe gaps.
    always @(negedge clk_50) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
        if (gap_en && !dout_oe) gap_seen = 1'b1;
    end

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp_word;
        logic [2:0]  exp_last;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ch_data[k*DATA_W +: DATA_W] = v;
    endtask

    function automatic logic din_for(input logic [2:0] a, input int k);
        case (k)
            2:       return a[2];
            3:       return a[1];
            4:       return a[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic sck_cycle(input logic d, output logic q);
        adc_sck = 1'b0;
        din     = d;
        repeat (HALF) @(negedge clk_50);
        q       = dout;
        adc_sck = 1'b1;
        repeat (HALF) @(negedge clk_50);
    endtask

    task automatic run_bits(input logic [2:0] a, input int first, input int last,
                            inout logic [15:0] w);
        logic b;
        for (int k = first; k <= last; k++) begin
            sck_cycle(din_for(a, k), b);
            w[15-k] = b;
        end
    endtask

    task automatic cs_low();
        adc_cs_n = 1'b0;
        repeat (6) @(negedge clk_50);
    endtask

    task automatic cs_high();
        adc_cs_n = 1'b1;
        repeat (6) @(negedge clk_50);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] wb;
        int d0;
        int a0;

        vecs[0] = '{addr: 3'd3, exp_word: 16'h0ABC, exp_last: 3'd3};
        vecs[1] = '{addr: 3'd5, exp_word: 16'h014D, exp_last: 3'd5};
        vecs[2] = '{addr: 3'd2, exp_word: 16'h0555, exp_last: 3'd2};
        vecs[3] = '{addr: 3'd4, exp_word: 16'h0222, exp_last: 3'd4};

        rst_n    = 1'b0;
        adc_cs_n = 1'b1;
        adc_sck  = 1'b1;
        din      = 1'b0;
        ch_data  = '0;
        set_ch(0, 12'hABC);
        set_ch(1, 12'h001);
        set_ch(2, 12'h222);
        set_ch(3, 12'h14D);
        set_ch(4, 12'h444);
        set_ch(5, 12'h555);
        set_ch(6, 12'hFFF);
        set_ch(7, 12'h7E7);

        // Reset held while inputs toggle.
        @(negedge clk_50);
        for (int i = 0; i < 10; i++) begin
            adc_cs_n = ~adc_cs_n;
            adc_sck  = ~adc_sck;
            din      = ~din;
            @(negedge clk_50);
        end
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_oe", 32'(dout_oe), 32'd0);
        chk("rst_last", 32'(last_addr), 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);
        chk("rst_abort", 32'(abort_cnt), 32'd0);
        adc_cs_n = 1'b1;
        adc_sck  = 1'b1;
        din      = 1'b0;
        repeat (4) @(negedge clk_50);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_50);

        // Table-driven single frames: each returns the previous frame's channel.
        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            w  = 16'h0000;
            cs_low();
            run_bits(vecs[i].addr, 0, 15, w);
            cs_high();
            chk($sformatf("vec%0d_word", i), 32'(w), 32'(vecs[i].exp_word));
            chk($sformatf("vec%0d_last", i), 32'(last_addr), 32'(vecs[i].exp_last));
            chk($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'd1);
        end
        chk("table_abort", 32'(abort_cnt), 32'd0);

        // Continuous mode: 32 SCK with CS held low.
        d0 = done_cnt;
        w  = 16'h0000;
        wb = 16'h0000;
        cs_low();
        gap_en = 1'b1;
        run_bits(3'd6, 0, 15, w);
        run_bits(3'd1, 0, 15, wb);
        gap_en = 1'b0;
        cs_high();
        chk("cont_word_a", 32'(w), 32'h0444);
        chk("cont_word_b", 32'(wb), 32'h0FFF);
        chk("cont_done", 32'(done_cnt - d0), 32'd2);
        chk("cont_oe_gap", 32'(gap_seen), 32'd0);
        chk("cont_last", 32'(last_addr), 32'd1);

        // Abort after 9 SCK rises with address 7.
        a0 = abort_cnt;
        d0 = done_cnt;
        w  = 16'h0000;
        cs_low();
        run_bits(3'd7, 0, 8, w);
        adc_cs_n = 1'b1;
        repeat (3) @(negedge clk_50);
        chk("abort_oe", 32'(dout_oe), 32'd0);
        repeat (6) @(negedge clk_50);
        chk("abort_pulse", 32'(abort_cnt - a0), 32'd1);
        chk("abort_last", 32'(last_addr), 32'd1);
        chk("abort_nodone", 32'(done_cnt - d0), 32'd0);

        // Snapshot: ch1 changes mid-frame, returned word keeps the old value.
        w = 16'h0000;
        cs_low();
        run_bits(3'd4, 0, 5, w);
        set_ch(1, 12'hF0F);
        run_bits(3'd4, 6, 15, w);
        cs_high();
        chk("snap_word", 32'(w), 32'h0001);
        chk("snap_last", 32'(last_addr), 32'd4);

        // Reset in the middle of a frame (after 10 SCK rises, dout is 1 here).
        a0 = abort_cnt;
        w  = 16'h0000;
        cs_low();
        run_bits(3'd5, 0, 9, w);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_oe", 32'(dout_oe), 32'd0);
        chk("mid_rst_last", 32'(last_addr), 32'd0);
        @(negedge clk_50);
        adc_cs_n = 1'b1;
        adc_sck  = 1'b1;
        din      = 1'b0;
        repeat (4) @(negedge clk_50);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_50);
        chk("mid_rst_abort", 32'(abort_cnt - a0), 32'd0);

        // After reset the next frame returns channel 0.
        w = 16'h0000;
        cs_low();
        run_bits(3'd2, 0, 15, w);
        cs_high();
        chk("post_rst_word", 32'(w), 32'h0ABC);
        chk("post_rst_last", 32'(last_addr), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable responder for the 3-wire ADC serial interface (CS_N, SCK, DIN in; DOUT out), emulating the 8-channel, 12-bit ADC that our ADC master and line-follower sensor path talk to. It sits on the FPGA side in place of the physical converter. Per-channel sample values are supplied as parallel inputs, so the master, thresholding and PID loop can be exercised in hardware loopback and in simulation without analog sensors. All logic runs in the system clock domain; the master's SCK is oversampled, not used as a clock.

## Interface
Parameters:
- DATA_W, 12, sample width in bits.
- NCH, 8, number of channels; the address field is 3 bits.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- adc_cs_n  in  1  chip select from master; a frame is active while low.
- adc_sck  in  1  serial clock from master; idles high.
- din  in  1  address bits from master.
- ch_data  in  NCH*DATA_W  channel samples; channel k is [k*DATA_W +: DATA_W].
- dout  out  1  serial sample data to master.
- dout_oe  out  1  high while a frame is active; external tri-state enable.
- frame_done  out  1  one-cycle pulse after the 16th SCK rising edge.
- frame_abort  out  1  one-cycle pulse when CS_N rises mid-frame.
- last_addr  out  3  address captured in the most recent completed frame.

## Operation
- adc_cs_n, adc_sck and din each pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized values: SCK rise, SCK fall, CS fall and CS rise.
- States:
  - IDLE: CS_N high, dout_oe=0, dout=0.
  - ACTIVE: CS_N low; bit counter bit_idx runs 0..15.
- Entering ACTIVE on CS fall:
  - bit_idx=0.
  - dout_oe=1.
  - Snapshot ch_data[addr_cur] into a 16-bit shift word {4'b0, sample}.
  - Drive bit 0 on dout.
- SCK rise at bit_idx k:
  - Sample din.
  - k=2, 3, 4 load addr_nxt[2], [1], [0] respectively.
- SCK fall: bit_idx increments and dout takes the next shift-word bit, MSB first. Bits 0–3 are 0; bits 4–15 are sample[11:0].
- After the SCK rise at bit_idx=15:
  - Pulse frame_done.
  - addr_cur <= addr_nxt; last_addr <= addr_nxt.
  - The channel addressed in frame N is returned in frame N+1. addr_cur is 0 after reset.
- Continuous mode: if CS_N stays low, the SCK fall after bit 15 wraps bit_idx to 0 and re-snapshots from the new addr_cur. This is identical to a fresh CS fall, except dout_oe stays high.
- CS rise while ACTIVE:
  - Before the bit-15 rise: pulse frame_abort; addr_cur and last_addr are unchanged.
  - After the bit-15 rise: no pulse.
  - Either way, go to IDLE.
- ch_data changes after the snapshot do not affect the frame in progress.
- SCK edges while IDLE are ignored.
- Simultaneous CS rise and SCK edge in the same clk_50 cycle: CS rise wins and the SCK edge is discarded.
- Reset, asynchronous and at any time:
  - State IDLE, bit_idx=0, addr_cur=0, addr_nxt=0.
  - dout=0, dout_oe=0, frame_done=0, frame_abort=0, last_addr=0.

## Timing
- Input-to-action latency is SYNC_STAGES+1 clk_50 cycles. With the default this is 3 cycles (60 ns) from a pin edge to the registered dout/dout_oe change.
- SCK high time and low time must each be ≥ SYNC_STAGES+2 clk_50 cycles. This gives a maximum SCK of 6.25 MHz at the defaults; the master runs 0.8–3.2 MHz.
- CS_N setup to the first SCK fall must be ≥ 4 clk_50 cycles.
- dout is valid from 3 cycles after each SCK fall until the next SCK fall. The master samples on SCK rise.
- frame_done and frame_abort are registered and last exactly one clk_50 cycle.

## Structure
- Package adc_spi_pkg holds:
  - FRAME_BITS=16, LEAD_ZEROS=4, ADDR_MSB_BIT=2, ADDR_W=3.
  - The state enum {IDLE, ACTIVE}.
- Sub-module sig_sync is one instance per input. It contains the SYNC_STAGES flip-flop chain, outputs the synchronized level, and provides rise/fall pulses.
- The top level holds the FSM, bit counter, shift word and address registers.

## Test plan
- Reset: hold rst_n low and toggle the inputs → dout=0, dout_oe=0, no pulses, last_addr=0.
- First frame: ch0=0xABC, DIN address 3'b011 → dout bits 0000_1010_1011_1100, frame_done once, last_addr=3.
- Second frame: ch3=0x14D, DIN address 5 → returns 0x14D, last_addr=5.
- Continuous mode: CS_N held low for 32 SCK, addresses 6 then 1, ch6=0xFFF, ch1=0x001 → two frame_done pulses with no gap in dout_oe; the second frame returns 0xFFF.
- Abort: CS_N rises after 9 SCK rises with DIN address 7 → frame_abort pulse, last_addr unchanged, dout_oe=0 within 3 cycles; the next frame returns the previously addressed channel.
- Snapshot and reset: ch_data changes at bit 6 → shifted word unchanged. rst_n asserted at bit 10 → immediate IDLE and outputs 0; the next frame returns ch0.
